msk_rnd_source: RTL and testbench

Fresh-randomness producer for masked gadgets. Holds a 128-bit Fibonacci LFSR seeded over a 32-bit valid/ready port, and emits `n_rnd = d*(d-1)/2` new bits per advance on the `rnd` bus consumed by the order-d masked multipliers. It sits between the platform TRNG/seed interface and the masked datapath, and is the supply end of every gadget's `rnd` input.

---
 rtl/msk_rnd_source.sv | 129 ++++++++++++
 tb/tb_msk_rnd_source.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_rnd_source.sv
// msk_rnd_source: 128-bit LFSR fresh-randomness source for order-d gadgets.
// Define MSK_RND_SOURCE_STATS_EN to enable the rnd_cnt advance counter.
module msk_rnd_source #(
   parameter int d          = 2,
   parameter int WARMUP_CYC = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          seed_data,
   input  logic                 seed_valid,
   output logic                 seed_ready,
   output logic                 seed_err,
   output logic [d*(d-1)/2-1:0] rnd,
   output logic                 rnd_valid,
   input  logic                 rnd_en,
   output logic [31:0]          rnd_cnt
);

   localparam int N_RND = d * (d - 1) / 2;

   typedef enum logic [1:0] {
      UNSEEDED,
      LOADING,
      WARMUP,
      RUNNING
   } state_t;

   state_t       state_q, state_d;
   logic [127:0] s_q, s_d;
   logic [1:0]   wcnt_q, wcnt_d;
   logic [7:0]   wucnt_q, wucnt_d;
   logic         err_q, err_d;
   logic         hs;

   // n_rnd unrolled Fibonacci steps; newest bit lands in bit 0
   function automatic logic [127:0] advance(input logic [127:0] x);
      logic [127:0] t;
      t = x;
      for (int i = 0; i < N_RND; i++)
         t = {t[126:0], t[127] ^ t[125] ^ t[100] ^ t[98]};
      return t;
   endfunction

   assign seed_ready = (state_q != WARMUP);
   assign rnd_valid  = (state_q == RUNNING);
   assign seed_err   = err_q;
   assign rnd        = s_q[N_RND-1:0];
   assign hs         = seed_valid & seed_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= UNSEEDED;
         s_q     <= '0;
         wcnt_q  <= '0;
         wucnt_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         wcnt_q  <= wcnt_d;
         wucnt_q <= wucnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      wcnt_d  = wcnt_q;
      wucnt_d = wucnt_q;
      err_d   = err_q;
      unique case (state_q)
         UNSEEDED, RUNNING: begin
            // a seed word wins over a simultaneous advance
            if (hs) begin
               s_d[31:0] = seed_data;
               wcnt_d    = 2'd1;
               err_d     = 1'b0;
               state_d   = LOADING;
            end else if (rnd_valid && rnd_en) begin
               s_d = advance(s_q);
            end
         end
         LOADING: begin
            if (hs) begin
               s_d[{wcnt_q, 5'd0} +: 32] = seed_data;
               err_d  = 1'b0;
               wcnt_d = wcnt_q + 2'd1;
               if (wcnt_q == 2'd3) begin
                  if (s_d == '0) begin
                     err_d   = 1'b1;
                     state_d = UNSEEDED;
                  end else if (WARMUP_CYC == 0) begin
                     state_d = RUNNING;
                  end else begin
                     wucnt_d = 8'(WARMUP_CYC);
                     state_d = WARMUP;
                  end
               end
            end
         end
         WARMUP: begin
            s_d     = advance(s_q);
            wucnt_d = wucnt_q - 8'd1;
            if (wucnt_q == 8'd1)
               state_d = RUNNING;
         end
         default: begin
            state_d = UNSEEDED;
         end
      endcase
   end

`ifdef MSK_RND_SOURCE_STATS_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (rnd_valid && rnd_en && !hs && cnt_q != '1)
         cnt_q <= cnt_q + 32'd1;
   end

   assign rnd_cnt = cnt_q;
`else
   assign rnd_cnt = '0;
`endif

endmodule

// File: tb/tb_msk_rnd_source.sv
// tb_msk_rnd_source: vector table, directed corners and a random run
// against a reference model, on a d=2/no-warmup and a d=3/warmup-3 instance.
module tb_msk_rnd_source;

   localparam int P_IDLE = 0;
   localparam int P_LOAD = 1;
   localparam int P_WARM = 2;
   localparam int P_RUN  = 3;
   localparam logic [127:0] TAPS =
      (128'd1 << 127) | (128'd1 << 125) | (128'd1 << 100) | (128'd1 << 98);

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] seed_data;
   logic        seed_valid;
   logic        rnd_en;

   logic        seed_ready_a, seed_err_a, rnd_valid_a;
   logic [0:0]  rnd_a;
   logic [31:0] rnd_cnt_a;
   logic        seed_ready_b, seed_err_b, rnd_valid_b;
   logic [2:0]  rnd_b;
   logic [31:0] rnd_cnt_b;

   int n_cmp = 0;
   int n_bad = 0;

   logic [127:0] m_s[2];
   int           m_ph[2];
   int           m_k[2];
   int           m_wu[2];
   bit           m_err[2];
   logic [31:0]  m_cnt[2];
   int           NR[2] = '{1, 3};
   int           WC[2] = '{0, 3};

   typedef struct {
      bit          v;
      logic [31:0] dat;
      bit          e;
      bit          x_valid;
      bit          x_rnd;
      bit          x_err;
      bit          x_ready;
   } vec_t;

   vec_t tbl[18];

   always #5 clk = ~clk;

   msk_rnd_source #(.d(2), .WARMUP_CYC(0)) u_a (
      .clk(clk), .rst_n(rst_n),
      .seed_data(seed_data), .seed_valid(seed_valid),
      .seed_ready(seed_ready_a), .seed_err(seed_err_a),
      .rnd(rnd_a), .rnd_valid(rnd_valid_a),
      .rnd_en(rnd_en), .rnd_cnt(rnd_cnt_a)
   );

   msk_rnd_source #(.d(3), .WARMUP_CYC(3)) u_b (
      .clk(clk), .rst_n(rst_n),
      .seed_data(seed_data), .seed_valid(seed_valid),
      .seed_ready(seed_ready_b), .seed_err(seed_err_b),
      .rnd(rnd_b), .rnd_valid(rnd_valid_b),
      .rnd_en(rnd_en), .rnd_cnt(rnd_cnt_b)
   );

   function automatic logic [127:0] madv(input logic [127:0] x, input int n);
      for (int i = 0; i < n; i++)
         x = {x[126:0], ^(x & TAPS)};
      return x;
   endfunction

   task automatic chk(input string nm, input logic [127:0] got,
                      input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h", nm, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_s[i]   = '0;
         m_ph[i]  = P_IDLE;
         m_k[i]   = 0;
         m_wu[i]  = 0;
         m_err[i] = 1'b0;
         m_cnt[i] = '0;
      end
   endtask

   task automatic model_edge(input int i);
      logic [127:0] s;
      int k;
      bit h;
      s = m_s[i];
      h = seed_valid && (m_ph[i] != P_WARM);
      if (h) begin
         k = (m_ph[i] == P_LOAD) ? m_k[i] : 0;
         s[32*k +: 32] = seed_data;
         m_err[i] = 1'b0;
         m_k[i]   = k + 1;
         m_ph[i]  = P_LOAD;
         if (m_k[i] == 4) begin
            m_k[i] = 0;
            if (s == '0) begin
               m_err[i] = 1'b1;
               m_ph[i]  = P_IDLE;
            end else if (WC[i] == 0) begin
               m_ph[i] = P_RUN;
            end else begin
               m_ph[i] = P_WARM;
               m_wu[i] = WC[i];
            end
         end
      end else if (m_ph[i] == P_WARM) begin
         s = madv(s, NR[i]);
         m_wu[i]--;
         if (m_wu[i] == 0)
            m_ph[i] = P_RUN;
      end else if (m_ph[i] == P_RUN && rnd_en) begin
         s = madv(s, NR[i]);
         if (m_cnt[i] != 32'hFFFF_FFFF)
            m_cnt[i]++;
      end
      m_s[i] = s;
   endtask

   function automatic logic [31:0] exp_cnt(input int i);
`ifdef MSK_RND_SOURCE_STATS_EN
      return m_cnt[i];
`else
      return 32'd0;
`endif
   endfunction

   task automatic check_all();
      chk("a.rnd", rnd_a, m_s[0][0:0]);
      chk("a.valid", rnd_valid_a, m_ph[0] == P_RUN);
      chk("a.ready", seed_ready_a, m_ph[0] != P_WARM);
      chk("a.err", seed_err_a, m_err[0]);
      chk("a.cnt", rnd_cnt_a, exp_cnt(0));
      chk("b.rnd", rnd_b, m_s[1][2:0]);
      chk("b.valid", rnd_valid_b, m_ph[1] == P_RUN);
      chk("b.ready", seed_ready_b, m_ph[1] != P_WARM);
      chk("b.err", seed_err_b, m_err[1]);
      chk("b.cnt", rnd_cnt_b, exp_cnt(1));
   endtask

   task automatic cyc(input bit v, input logic [31:0] dat, input bit e);
      seed_valid = v;
      seed_data  = dat;
      rnd_en     = e;
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      seed_valid = 1'b0;
      seed_data  = '0;
      rnd_en     = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int k;
      bit seen;
      tbl[0]  = '{1, 32'h1, 0, 0, 1, 0, 1};
      tbl[1]  = '{1, 32'h0, 0, 0, 1, 0, 1};
      tbl[2]  = '{1, 32'h0, 0, 0, 1, 0, 1};
      tbl[3]  = '{1, 32'h0, 0, 1, 1, 0, 1};
      tbl[4]  = '{0, 32'h0, 0, 1, 1, 0, 1};
      tbl[5]  = '{0, 32'h0, 1, 1, 0, 0, 1};
      tbl[6]  = '{1, 32'h0, 1, 0, 0, 0, 1};
      tbl[7]  = '{1, 32'h0, 0, 0, 0, 0, 1};
      tbl[8]  = '{1, 32'h0, 0, 0, 0, 0, 1};
      tbl[9]  = '{1, 32'h0, 0, 0, 0, 1, 1};
      tbl[10] = '{0, 32'h0, 1, 0, 0, 1, 1};
      tbl[11] = '{1, 32'h5, 0, 0, 1, 0, 1};
      tbl[12] = '{1, 32'h0, 0, 0, 1, 0, 1};
      tbl[13] = '{1, 32'h0, 0, 0, 1, 0, 1};
      tbl[14] = '{1, 32'h0, 0, 1, 1, 0, 1};
      tbl[15] = '{0, 32'h0, 1, 1, 0, 0, 1};
      tbl[16] = '{0, 32'h0, 0, 1, 0, 0, 1};
      tbl[17] = '{0, 32'h0, 1, 1, 0, 0, 1};

      do_reset();
      chk("rst.valid", rnd_valid_a, 1'b0);
      chk("rst.ready", seed_ready_a, 1'b1);

      for (int j = 0; j < 18; j++) begin
         cyc(tbl[j].v, tbl[j].dat, tbl[j].e);
         chk($sformatf("tbl%0d.valid", j), rnd_valid_a, tbl[j].x_valid);
         chk($sformatf("tbl%0d.rnd", j), rnd_a, tbl[j].x_rnd);
         chk($sformatf("tbl%0d.err", j), seed_err_a, tbl[j].x_err);
         chk($sformatf("tbl%0d.ready", j), seed_ready_a, tbl[j].x_ready);
      end

      // reset in the middle of a load discards the partial seed
      do_reset();
      cyc(1, 32'h7, 0);
      cyc(1, 32'h0, 0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst.valid", rnd_valid_a, 1'b0);
      chk("midrst.ready", seed_ready_a, 1'b1);
      chk("midrst.err", seed_err_a, 1'b0);
      chk("midrst.rnd_a", rnd_a, 1'b0);
      chk("midrst.rnd_b", rnd_b, 3'd0);
      chk("midrst.cnt", rnd_cnt_a, 32'd0);
      check_all();
      #2 rst_n = 1'b1;
      cyc(1, 32'h0, 0);
      cyc(1, 32'h0, 0);
      cyc(1, 32'h0, 0);
      chk("midrst.need4", rnd_valid_a, 1'b0);
      cyc(1, 32'h9, 0);
      chk("midrst.full", rnd_valid_a, 1'b1);

      // warmup: valid exactly WARMUP_CYC edges after the last word
      do_reset();
      cyc(1, 32'h1, 0);
      cyc(1, 32'h0, 0);
      cyc(1, 32'h0, 0);
      cyc(1, 32'h0, 0);
      chk("warm.a_now", rnd_valid_a, 1'b1);
      chk("warm.b_busy", seed_ready_b, 1'b0);
      k = 0;
      seen = 1'b0;
      for (int j = 1; j <= 10 && !seen; j++) begin
         cyc(0, 32'h0, 0);
         if (rnd_valid_b) begin
            k = j;
            seen = 1'b1;
         end
      end
      chk("warm.edges", k, 3);
      chk("warm.rnd", rnd_b, 3'd0);
      chk("warm.s", m_s[1], 128'd1 << 9);

      // reseed with simultaneous rnd_en: no advance, valid drops
      cyc(0, 32'h0, 1);
      cyc(0, 32'h0, 1);
      cyc(1, 32'h3, 1);
      chk("reseed.valid_a", rnd_valid_a, 1'b0);
      chk("reseed.valid_b", rnd_valid_b, 1'b0);
      chk("reseed.cnt_a", rnd_cnt_a, exp_cnt(0));
      cyc(1, 32'h0, 1);
      cyc(1, 32'h0, 1);
      cyc(1, 32'h0, 1);

      // 1000 accepted advances
      do_reset();
      cyc(1, 32'h1, 0);
      cyc(1, 32'h0, 0);
      cyc(1, 32'h0, 0);
      cyc(1, 32'h0, 0);
      for (int j = 0; j < 3; j++)
         cyc(0, 32'h0, 0);
      for (int j = 0; j < 1000; j++)
         cyc(0, 32'h0, 1);
`ifdef MSK_RND_SOURCE_STATS_EN
      chk("stats.a", rnd_cnt_a, 32'd1000);
      chk("stats.b", rnd_cnt_b, 32'd1000);
`else
      chk("stats.a", rnd_cnt_a, 32'd0);
      chk("stats.b", rnd_cnt_b, 32'd0);
`endif

      // random traffic against the model
      for (int j = 0; j < 3000; j++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            cyc($urandom_range(0, 7) == 0,
                ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom),
                $urandom_range(0, 1) == 1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
